instruction_decode_hs: RTL and testbench
========================================

// Module: instruction_decode_hs
// PURPOSE
// Parametrised decode stage with a valid/ready handshake on both sides. It sits between fetch and execute.
// Each accepted instruction is decoded by the existing control_unit and imm_gen. Register operands come from
// an internal register file. The result is registered into a single ID/EX slot.
// Beyond the current decode stage it adds: downstream back-pressure; a multi-cycle load-use stall counter;
// WB-to-ID bypass; and refresh of operands while an instruction is held.
// PARAMETERS
// XLEN             32           datapath width (rs data, imm, pc)
// REG_COUNT        32           architectural registers; label width LW = $clog2(REG_COUNT)
// LOAD_USE_STALL   1            bubbles inserted per load-use hazard (1..7)
// WB_BYPASS        1            1: same-cycle WB write is forwarded to rs reads; 0: register-file read only
// RESET_PC         {XLEN{1'b1}}<<2  pc_o value after reset and on bubble (i.e. -4)
// PORTS
// clk_i          in   1     clock, rising edge
// rst_i          in   1     asynchronous reset, active-high
// if_valid_i     in   1     fetch offers instr_i/pc_i
// if_ready_o     out  1     decode accepts this cycle
// instr_i        in   32    instruction word
// pc_i           in   XLEN  pc of instr_i
// flush_i        in   1     branch taken in EX: kill slot and offered instruction
// ex_ready_i     in   1     execute consumes slot this cycle
// id_valid_o     out  1     slot holds a real instruction
// rs1_data_o     out  XLEN  rs1 operand
// rs2_data_o     out  XLEN  rs2 operand
// imm_o          out  XLEN  immediate
// pc_o           out  XLEN  pc of slot instruction
// rd_o           out  LW    destination label
// rs1_o          out  LW    rs1 label
// rs2_o          out  LW    rs2 label
// funct3_o       out  3     funct3 field
// ctrl_o         out  14    {ld_st_fwd,uncond_br,alu_op[3:0],wb_sel[1:0],is_load,is_store,is_branch,rs2_imm_sel,rs1_pc_sel,reg_we}
// ex_is_load_i   in   1     instruction in EX is a load
// ex_rd_i        in   LW    rd of instruction in EX
// wb_we_i        in   1     writeback enable
// wb_rd_i        in   LW    writeback label
// wb_data_i      in   XLEN  writeback value
// BEHAVIOUR
// - Reset (async):
//   - id_valid_o=0, ctrl_o=0, data/label outputs=0, pc_o=RESET_PC, stall counter=0, regfile all 0.
// - Register file:
//   - x0 reads 0 and is never written.
//   - Write at posedge when wb_we_i && wb_rd_i!=0.
//   - WB_BYPASS=1: rsN==wb_rd_i!=0 && wb_we_i selects wb_data_i.
// - Advance condition: adv = !id_valid_o || ex_ready_i.
// - if_ready_o = flush_i | (adv & (cnt==0) & !hazard).
// - Load-use hazard:
//   - hazard = if_valid_i & ex_is_load_i & ex_rd_i!=0 & (rs1==ex_rd_i | (rs2==ex_rd_i & !is_store)).
//   - A store whose rs2 only matches is not a hazard; it sets ld_st_fwd=1 instead.
// - Per-edge priority:
//   1. flush_i: id_valid_o<=0, ctrl_o<=0, pc_o<=RESET_PC, cnt<=0; the offered instruction is dropped.
//   2. !adv (hold): all outputs keep their value, except the operand refresh below.
//   3. cnt!=0: bubble (id_valid_o<=0, ctrl_o<=0, pc_o<=RESET_PC); cnt<=cnt-1.
//   4. hazard: bubble; cnt<=LOAD_USE_STALL-1.
//   5. if_valid_i: load the decoded instruction; id_valid_o<=1.
//   6. otherwise: bubble.
// - Hold refresh:
//   - Applies while id_valid_o && !adv.
//   - A WB write with wb_rd_i==rs1_o (resp. rs2_o), label !=0, updates rs1_data_o (resp. rs2_data_o).
// - Latency: 1 cycle from accept to id_valid_o. Throughput: 1 per cycle with no hazard.
// - Bubbles never assert reg_we, is_store, is_branch or uncond_br.
// - cnt is 3 bits; LOAD_USE_STALL outside 1..7 is an elaboration error.
// TESTING
// - Reset mid-stream, slot holding addi x1,x0,5:
//   - Assert rst_i between edges -> outputs 0 at once, pc_o=FFFF_FFFC, id_valid_o=0.
// - lw x2,0(x1) in EX, then add x3,x2,x4 with LOAD_USE_STALL=2:
//   - 2 bubbles (if_ready_o=0 for 2 cycles), then add is accepted.
// - lw x2 in EX, then sw x2,4(x5) -> no stall, ctrl_o[13]=1.
// - ex_ready_i=0 for 3 cycles with add x3,x1,x2 held, WB writes x1=0xDEAD in cycle 2:
//   - outputs stable, except rs1_data_o=0xDEAD from the next cycle.
// - flush_i with ex_ready_i=0 and a hazard pending:
//   - next cycle id_valid_o=0, ctrl_o=0, cnt=0, if_ready_o=1 during the flush cycle.
// - Same-cycle WB x7=0x1234 while decoding add x8,x7,x7:
//   - WB_BYPASS=1 -> both rs data = 0x1234.
//   - WB_BYPASS=0 -> old x7.

Source files
------------

// File: rtl/instruction_decode_hs.sv
// -----------------------------------------------------------------------------
// instruction_decode_hs
// RV32I decode stage between fetch and execute. Valid/ready handshake on both
// sides, single registered ID/EX slot, internal register file with optional
// WB-to-ID bypass, multi-cycle load-use stall and operand refresh while the
// slot is held by downstream back-pressure.
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   if_valid_i/if_ready_o fetch handshake; instr_i, pc_i offered instruction
//   flush_i               kill the slot and the offered instruction
//   ex_ready_i            execute consumes the slot this cycle
//   id_valid_o            slot holds a real instruction
//   rs1_data_o/rs2_data_o register operands of the slot instruction
//   imm_o, pc_o           immediate and pc of the slot instruction
//   rd_o, rs1_o, rs2_o    register labels, funct3_o funct3 field
//   ctrl_o                {ld_st_fwd,uncond_br,alu_op[3:0],wb_sel[1:0],
//                          is_load,is_store,is_branch,rs2_imm_sel,rs1_pc_sel,reg_we}
//   ex_is_load_i, ex_rd_i instruction currently in EX (load-use detection)
//   wb_we_i, wb_rd_i, wb_data_i  writeback port into the register file
//
// alu_op: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND 10 PASSB
// wb_sel: 0 ALU result, 1 load data, 2 pc+4
// -----------------------------------------------------------------------------
module instruction_decode_hs #(
    parameter int unsigned       XLEN           = 32,
    parameter int unsigned       REG_COUNT      = 32,
    parameter int unsigned       LOAD_USE_STALL = 1,
    parameter int unsigned       WB_BYPASS      = 1,
    parameter logic [XLEN-1:0]   RESET_PC       = {XLEN{1'b1}} << 2,
    localparam int unsigned      LW             = $clog2(REG_COUNT)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output logic [LW-1:0]   rd_o,
    output logic [LW-1:0]   rs1_o,
    output logic [LW-1:0]   rs2_o,
    output logic [2:0]      funct3_o,
    output logic [13:0]     ctrl_o,
    input  logic            ex_is_load_i,
    input  logic [LW-1:0]   ex_rd_i,
    input  logic            wb_we_i,
    input  logic [LW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i
);

    localparam int unsigned CW = 3;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Stall length is held in a 3-bit counter.
    if (LOAD_USE_STALL == 0 || LOAD_USE_STALL > 7) begin : g_bad_stall
        $error("LOAD_USE_STALL must be in 1..7");
    end

    // ---------------------------------------------------------------- state
    logic [XLEN-1:0] r_rf [REG_COUNT];
    logic            r_valid;
    logic [XLEN-1:0] r_rs1_data, r_rs2_data, r_imm, r_pc;
    logic [LW-1:0]   r_rd, r_rs1, r_rs2;
    logic [2:0]      r_funct3;
    logic [13:0]     r_ctrl;
    logic [CW-1:0]   r_cnt;

    // ---------------------------------------------------------------- wires
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [LW-1:0]   w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0] w_imm;
    logic [3:0]      w_alu_op;
    logic [1:0]      w_wb_sel;
    logic            w_is_load, w_is_store, w_is_branch, w_uncond_br;
    logic            w_rs2_imm_sel, w_rs1_pc_sel, w_reg_we, w_ld_st_fwd;
    logic [13:0]     w_ctrl;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data;
    logic            w_wb_hit;
    logic            w_adv, w_hazard, w_ex_match1, w_ex_match2;

    logic            w_nxt_valid;
    logic [XLEN-1:0] w_nxt_rs1_data, w_nxt_rs2_data, w_nxt_imm, w_nxt_pc;
    logic [LW-1:0]   w_nxt_rd, w_nxt_rs1, w_nxt_rs2;
    logic [2:0]      w_nxt_funct3;
    logic [13:0]     w_nxt_ctrl;
    logic [CW-1:0]   w_nxt_cnt;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_rd     = LW'(instr_i[11:7]);
    assign w_rs1    = LW'(instr_i[19:15]);
    assign w_rs2    = LW'(instr_i[24:20]);

    // Control decode
    always_comb begin
        w_alu_op      = ALU_ADD;
        w_wb_sel      = WB_ALU;
        w_is_load     = 1'b0;
        w_is_store    = 1'b0;
        w_is_branch   = 1'b0;
        w_uncond_br   = 1'b0;
        w_rs2_imm_sel = 1'b0;
        w_rs1_pc_sel  = 1'b0;
        w_reg_we      = 1'b0;
        unique case (w_opcode)
            OP_LUI: begin
                w_alu_op      = ALU_PASSB;
                w_rs2_imm_sel = 1'b1;
                w_reg_we      = 1'b1;
            end
            OP_AUIPC: begin
                w_rs1_pc_sel  = 1'b1;
                w_rs2_imm_sel = 1'b1;
                w_reg_we      = 1'b1;
            end
            OP_JAL: begin
                w_uncond_br   = 1'b1;
                w_wb_sel      = WB_PC4;
                w_rs1_pc_sel  = 1'b1;
                w_rs2_imm_sel = 1'b1;
                w_reg_we      = 1'b1;
            end
            OP_JALR: begin
                w_uncond_br   = 1'b1;
                w_wb_sel      = WB_PC4;
                w_rs2_imm_sel = 1'b1;
                w_reg_we      = 1'b1;
            end
            OP_BRANCH: begin
                w_is_branch   = 1'b1;
                w_alu_op      = ALU_SUB;
            end
            OP_LOAD: begin
                w_is_load     = 1'b1;
                w_wb_sel      = WB_MEM;
                w_rs2_imm_sel = 1'b1;
                w_reg_we      = 1'b1;
            end
            OP_STORE: begin
                w_is_store    = 1'b1;
                w_rs2_imm_sel = 1'b1;
            end
            OP_IMM, OP_REG: begin
                w_rs2_imm_sel = (w_opcode == OP_IMM);
                w_reg_we      = 1'b1;
                unique case (w_funct3)
                    3'd0: w_alu_op = (w_opcode == OP_REG && instr_i[30]) ? ALU_SUB : ALU_ADD;
                    3'd1: w_alu_op = ALU_SLL;
                    3'd2: w_alu_op = ALU_SLT;
                    3'd3: w_alu_op = ALU_SLTU;
                    3'd4: w_alu_op = ALU_XOR;
                    3'd5: w_alu_op = instr_i[30] ? ALU_SRA : ALU_SRL;
                    3'd6: w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_AND;
                endcase
            end
            default: ;
        endcase
    end

    // Immediate generation, sign-extended to XLEN
    always_comb begin
        w_imm = '0;
        unique case (w_opcode)
            OP_LUI, OP_AUIPC:
                w_imm = XLEN'($signed({instr_i[31:12], 12'b0}));
            OP_JAL:
                w_imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                       instr_i[30:21], 1'b0}));
            OP_BRANCH:
                w_imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                       instr_i[11:8], 1'b0}));
            OP_STORE:
                w_imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            OP_JALR, OP_LOAD, OP_IMM:
                w_imm = XLEN'($signed(instr_i[31:20]));
            default: w_imm = '0;
        endcase
    end

    // Load-use detection; a store that only needs the load result as store data
    // is not stalled but flagged so EX/MEM can forward it.
    assign w_ex_match1 = ex_is_load_i && (ex_rd_i != '0) && (w_rs1 == ex_rd_i);
    assign w_ex_match2 = ex_is_load_i && (ex_rd_i != '0) && (w_rs2 == ex_rd_i);
    assign w_hazard    = if_valid_i && (w_ex_match1 || (w_ex_match2 && !w_is_store));
    assign w_ld_st_fwd = w_is_store && w_ex_match2;

    assign w_ctrl = {w_ld_st_fwd, w_uncond_br, w_alu_op, w_wb_sel, w_is_load,
                     w_is_store, w_is_branch, w_rs2_imm_sel, w_rs1_pc_sel, w_reg_we};

    // Register-file read with optional same-cycle writeback bypass
    assign w_wb_hit = wb_we_i && (wb_rd_i != '0);

    always_comb begin
        w_rs1_data = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
        w_rs2_data = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
        if (WB_BYPASS != 0 && w_wb_hit && wb_rd_i == w_rs1) w_rs1_data = wb_data_i;
        if (WB_BYPASS != 0 && w_wb_hit && wb_rd_i == w_rs2) w_rs2_data = wb_data_i;
    end

    // Handshake
    assign w_adv      = !r_valid || ex_ready_i;
    assign if_ready_o = flush_i || (w_adv && (r_cnt == '0) && !w_hazard);

    // Slot next-state: flush > hold > stall countdown > new hazard > load > bubble
    always_comb begin
        w_nxt_valid    = r_valid;
        w_nxt_rs1_data = r_rs1_data;
        w_nxt_rs2_data = r_rs2_data;
        w_nxt_imm      = r_imm;
        w_nxt_pc       = r_pc;
        w_nxt_rd       = r_rd;
        w_nxt_rs1      = r_rs1;
        w_nxt_rs2      = r_rs2;
        w_nxt_funct3   = r_funct3;
        w_nxt_ctrl     = r_ctrl;
        w_nxt_cnt      = r_cnt;
        if (flush_i) begin
            w_nxt_valid = 1'b0;
            w_nxt_ctrl  = '0;
            w_nxt_pc    = RESET_PC;
            w_nxt_cnt   = '0;
        end else if (!w_adv) begin
            // Held slot tracks writebacks so EX sees current operands on release
            if (w_wb_hit && wb_rd_i == r_rs1) w_nxt_rs1_data = wb_data_i;
            if (w_wb_hit && wb_rd_i == r_rs2) w_nxt_rs2_data = wb_data_i;
        end else if (r_cnt != '0) begin
            w_nxt_valid = 1'b0;
            w_nxt_ctrl  = '0;
            w_nxt_pc    = RESET_PC;
            w_nxt_cnt   = r_cnt - CW'(1);
        end else if (w_hazard) begin
            w_nxt_valid = 1'b0;
            w_nxt_ctrl  = '0;
            w_nxt_pc    = RESET_PC;
            w_nxt_cnt   = CW'(LOAD_USE_STALL - 1);
        end else if (if_valid_i) begin
            w_nxt_valid    = 1'b1;
            w_nxt_rs1_data = w_rs1_data;
            w_nxt_rs2_data = w_rs2_data;
            w_nxt_imm      = w_imm;
            w_nxt_pc       = pc_i;
            w_nxt_rd       = w_rd;
            w_nxt_rs1      = w_rs1;
            w_nxt_rs2      = w_rs2;
            w_nxt_funct3   = w_funct3;
            w_nxt_ctrl     = w_ctrl;
        end else begin
            w_nxt_valid = 1'b0;
            w_nxt_ctrl  = '0;
            w_nxt_pc    = RESET_PC;
        end
    end

    // ID/EX slot and stall counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= RESET_PC;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_funct3   <= '0;
            r_ctrl     <= '0;
            r_cnt      <= '0;
        end else begin
            r_valid    <= w_nxt_valid;
            r_rs1_data <= w_nxt_rs1_data;
            r_rs2_data <= w_nxt_rs2_data;
            r_imm      <= w_nxt_imm;
            r_pc       <= w_nxt_pc;
            r_rd       <= w_nxt_rd;
            r_rs1      <= w_nxt_rs1;
            r_rs2      <= w_nxt_rs2;
            r_funct3   <= w_nxt_funct3;
            r_ctrl     <= w_nxt_ctrl;
            r_cnt      <= w_nxt_cnt;
        end
    end

    // Register file; x0 is never written
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(REG_COUNT); i++) r_rf[i] <= '0;
        end else if (w_wb_hit) begin
            r_rf[wb_rd_i] <= wb_data_i;
        end
    end

    assign id_valid_o = r_valid;
    assign rs1_data_o = r_rs1_data;
    assign rs2_data_o = r_rs2_data;
    assign imm_o      = r_imm;
    assign pc_o       = r_pc;
    assign rd_o       = r_rd;
    assign rs1_o      = r_rs1;
    assign rs2_o      = r_rs2;
    assign funct3_o   = r_funct3;
    assign ctrl_o     = r_ctrl;

endmodule

// File: tb/tb_instruction_decode_hs.sv
// Directed bench for instruction_decode_hs. Two instances share all inputs:
// u_dut uses WB bypass, u_dut_nb does not; both stall 2 cycles per load-use.
module tb_instruction_decode_hs;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_valid_i, flush_i, ex_ready_i, ex_is_load_i, wb_we_i;
    logic [31:0] instr_i, pc_i, wb_data_i;
    logic [4:0]  ex_rd_i, wb_rd_i;

    logic        if_ready_o, id_valid_o;
    logic [31:0] rs1_data_o, rs2_data_o, imm_o, pc_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    logic [13:0] ctrl_o;

    logic        nb_if_ready, nb_id_valid;
    logic [31:0] nb_rs1_data, nb_rs2_data, nb_imm, nb_pc;
    logic [4:0]  nb_rd, nb_rs1, nb_rs2;
    logic [2:0]  nb_funct3;
    logic [13:0] nb_ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    instruction_decode_hs #(.LOAD_USE_STALL(2), .WB_BYPASS(1)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .id_valid_o(id_valid_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .pc_o(pc_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .funct3_o(funct3_o), .ctrl_o(ctrl_o), .ex_is_load_i(ex_is_load_i),
        .ex_rd_i(ex_rd_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i));

    instruction_decode_hs #(.LOAD_USE_STALL(2), .WB_BYPASS(0)) u_dut_nb (
        .clk_i(clk_i), .rst_i(rst_i), .if_valid_i(if_valid_i), .if_ready_o(nb_if_ready),
        .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .id_valid_o(nb_id_valid), .rs1_data_o(nb_rs1_data), .rs2_data_o(nb_rs2_data),
        .imm_o(nb_imm), .pc_o(nb_pc), .rd_o(nb_rd), .rs1_o(nb_rs1), .rs2_o(nb_rs2),
        .funct3_o(nb_funct3), .ctrl_o(nb_ctrl), .ex_is_load_i(ex_is_load_i),
        .ex_rd_i(ex_rd_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_we_i = 1'b1; wb_rd_i = rd; wb_data_i = data;
        tick();
        wb_we_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; if_valid_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b0;
        ex_is_load_i = 1'b0; wb_we_i = 1'b0; instr_i = '0; pc_i = '0;
        wb_data_i = '0; ex_rd_i = '0; wb_rd_i = '0;

        // Reset state
        #12;
        chk("rst_valid", 32'(id_valid_o), 32'd0);
        chk("rst_ctrl",  32'(ctrl_o), 32'd0);
        chk("rst_pc",    pc_o, 32'hFFFF_FFFC);
        chk("rst_imm",   imm_o, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", 32'(if_ready_o), 32'd1);

        // addi x1,x0,5 accepted with one-cycle latency
        instr_i = 32'h0050_0093; pc_i = 32'h100; if_valid_i = 1'b1; ex_ready_i = 1'b1;
        #1;
        chk("addi_ready", 32'(if_ready_o), 32'd1);
        tick();
        chk("addi_valid", 32'(id_valid_o), 32'd1);
        chk("addi_ctrl",  32'(ctrl_o), 32'h0005);
        chk("addi_imm",   imm_o, 32'd5);
        chk("addi_rd",    32'(rd_o), 32'd1);
        chk("addi_pc",    pc_o, 32'h100);

        // Asynchronous reset between edges clears the slot immediately
        if_valid_i = 1'b0;
        #3 rst_i = 1'b1;
        #1;
        chk("mrst_valid", 32'(id_valid_o), 32'd0);
        chk("mrst_ctrl",  32'(ctrl_o), 32'd0);
        chk("mrst_pc",    pc_o, 32'hFFFF_FFFC);
        chk("mrst_imm",   imm_o, 32'd0);
        chk("mrst_rd",    32'(rd_o), 32'd0);
        #1 rst_i = 1'b0;

        // Preload register file
        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h22);
        wb_write(5'd4, 32'h44);
        wb_write(5'd5, 32'h55);
        wb_write(5'd7, 32'h77);

        // lw x2 in EX, add x3,x2,x4 offered: two bubbles then accept
        instr_i = 32'h0041_01B3; pc_i = 32'h200; if_valid_i = 1'b1;
        ex_is_load_i = 1'b1; ex_rd_i = 5'd2;
        #1;
        chk("lu_ready0", 32'(if_ready_o), 32'd0);
        tick();
        chk("lu_valid0", 32'(id_valid_o), 32'd0);
        chk("lu_pc0",    pc_o, 32'hFFFF_FFFC);
        ex_is_load_i = 1'b0;
        #1;
        chk("lu_ready1", 32'(if_ready_o), 32'd0);
        tick();
        chk("lu_valid1", 32'(id_valid_o), 32'd0);
        #1;
        chk("lu_ready2", 32'(if_ready_o), 32'd1);
        tick();
        chk("lu_valid2", 32'(id_valid_o), 32'd1);
        chk("lu_ctrl",   32'(ctrl_o), 32'h0001);
        chk("lu_rd",     32'(rd_o), 32'd3);
        chk("lu_rs2",    32'(rs2_o), 32'd4);
        chk("lu_rs1d",   rs1_data_o, 32'h22);
        chk("lu_rs2d",   rs2_data_o, 32'h44);

        // lw x2 in EX, sw x2,4(x5): no stall, ld_st_fwd set
        instr_i = 32'h0022_A223; pc_i = 32'h204; ex_is_load_i = 1'b1; ex_rd_i = 5'd2;
        #1;
        chk("st_ready", 32'(if_ready_o), 32'd1);
        tick();
        chk("st_ctrl",  32'(ctrl_o), 32'h2014);
        chk("st_imm",   imm_o, 32'd4);
        chk("st_f3",    32'(funct3_o), 32'd2);
        chk("st_rs1d",  rs1_data_o, 32'h55);
        chk("st_rs2d",  rs2_data_o, 32'h22);
        ex_is_load_i = 1'b0;

        // add x3,x1,x2 held for 3 cycles; WB x1=DEAD in cycle 2 refreshes rs1
        instr_i = 32'h0020_81B3; pc_i = 32'h208;
        tick();
        chk("hd_rs1d0", rs1_data_o, 32'h11);
        ex_ready_i = 1'b0; instr_i = 32'h0050_0093; pc_i = 32'h20C;
        #1;
        chk("hd_ready", 32'(if_ready_o), 32'd0);
        tick();
        chk("hd_rs1d1", rs1_data_o, 32'h11);
        chk("hd_pc1",   pc_o, 32'h208);
        wb_write(5'd1, 32'hDEAD);
        chk("hd_rs1d2", rs1_data_o, 32'hDEAD);
        chk("hd_rs2d2", rs2_data_o, 32'h22);
        chk("hd_ctrl2", 32'(ctrl_o), 32'h0001);
        chk("hd_valid2", 32'(id_valid_o), 32'd1);
        tick();
        chk("hd_rs1d3", rs1_data_o, 32'hDEAD);
        chk("hd_pc3",   pc_o, 32'h208);

        // Release: addi at 0x20C accepted
        ex_ready_i = 1'b1;
        tick();
        chk("rel_pc", pc_o, 32'h20C);

        // Flush with back-pressure and a pending hazard
        ex_ready_i = 1'b0; ex_is_load_i = 1'b1; ex_rd_i = 5'd2;
        instr_i = 32'h0041_01B3; pc_i = 32'h210; flush_i = 1'b1;
        #1;
        chk("fl_ready", 32'(if_ready_o), 32'd1);
        tick();
        chk("fl_valid", 32'(id_valid_o), 32'd0);
        chk("fl_ctrl",  32'(ctrl_o), 32'd0);
        chk("fl_pc",    pc_o, 32'hFFFF_FFFC);
        flush_i = 1'b0; ex_is_load_i = 1'b0;
        #1;
        chk("fl_cnt0", 32'(if_ready_o), 32'd1);

        // Flush during a stall countdown clears the counter
        ex_is_load_i = 1'b1;
        tick();
        ex_is_load_i = 1'b0; flush_i = 1'b1;
        #1;
        chk("flc_ready", 32'(if_ready_o), 32'd1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flc_cnt0", 32'(if_ready_o), 32'd1);
        tick();
        chk("flc_valid", 32'(id_valid_o), 32'd1);
        chk("flc_pc",    pc_o, 32'h210);

        // Same-cycle WB x7=1234 while decoding add x8,x7,x7
        ex_ready_i = 1'b1; instr_i = 32'h0073_8433; pc_i = 32'h214;
        wb_write(5'd7, 32'h1234);
        chk("byp_rs1d",   rs1_data_o, 32'h1234);
        chk("byp_rs2d",   rs2_data_o, 32'h1234);
        chk("nobyp_rs1d", nb_rs1_data, 32'h77);
        chk("nobyp_rs2d", nb_rs2_data, 32'h77);
        tick();
        chk("nobyp_after", nb_rs1_data, 32'h1234);

        // Write to x0 is ignored and never bypassed
        instr_i = 32'h0000_04B3; pc_i = 32'h218;
        wb_write(5'd0, 32'hFFFF);
        chk("x0_rs1d", rs1_data_o, 32'd0);
        chk("x0_rs2d", rs2_data_o, 32'd0);
        tick();
        chk("x0_rf",   rs1_data_o, 32'd0);

        // jal x1,8
        instr_i = 32'h0080_00EF; pc_i = 32'h21C;
        tick();
        chk("jal_ctrl", 32'(ctrl_o), 32'h1087);
        chk("jal_imm",  imm_o, 32'd8);
        chk("jal_rd",   32'(rd_o), 32'd1);

        // No offer: bubble with cleared control
        if_valid_i = 1'b0;
        tick();
        chk("bub_valid", 32'(id_valid_o), 32'd0);
        chk("bub_ctrl",  32'(ctrl_o), 32'd0);
        chk("bub_pc",    pc_o, 32'hFFFF_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
